// File: rtl/watchdog_reset_req_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : watchdog_reset_req_pkg
//  Description : Shared state encodings and small helpers for the watchdog
//                timer / reset-request block.
//  Revision    : 1.0  initial release
// ============================================================================
package watchdog_reset_req_pkg;

    // Watchdog state encodings. The values are fixed so they stay stable
    // across any debug/status readout that exposes the raw state.
    typedef enum logic [1:0] {
        WDT_IDLE = 2'd0,
        WDT_RUN  = 2'd1,
        WDT_WARN = 2'd2,
        WDT_FIRE = 2'd3
    } wdt_state_t;

    // The timeout counter only runs in RUN and WARN; both share the same
    // disable/kick/decrement handling.
    function automatic logic wdt_is_armed(input wdt_state_t state);
        return (state == WDT_RUN) || (state == WDT_WARN);
    endfunction

endpackage : watchdog_reset_req_pkg
`default_nettype wire

// File: rtl/watchdog_reset_req_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch
//  Description : Turns a single-cycle load strobe into a registered pulse that
//                is exactly PULSE cycles long. A strobe arriving while the
//                pulse is already high is ignored, so a running pulse is
//                never shortened or extended. last_o flags the final cycle of
//                the pulse so a controller can leave its waiting state on the
//                same edge the pulse drops.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_stretch #(
    parameter int PULSE = 8
) (
    input  logic clock,
    input  logic reset_ni,
    input  logic load_i,
    output logic pulse_o,
    output logic last_o
);

    // Remaining-cycle counter wide enough to hold PULSE.
    localparam int              c_PW   = (PULSE < 2) ? 1 : $clog2(PULSE + 1);
    localparam logic [c_PW-1:0] c_LOAD = c_PW'(PULSE - 1);
    localparam logic [c_PW-1:0] c_ONE  = c_PW'(1);

    logic [c_PW-1:0] r_cnt;
    logic            r_pulse;

    // Load on a strobe, then count the pulse down and drop it after PULSE cycles.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (r_pulse) begin
            if (r_cnt == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_ONE;
            end
        end else if (load_i) begin
            r_pulse <= 1'b1;
            r_cnt   <= c_LOAD;
        end
    end

    assign pulse_o = r_pulse;
    assign last_o  = r_pulse && (r_cnt == '0);

endmodule : pulse_stretch
`default_nettype wire

// File: rtl/watchdog_reset_req.sv
`default_nettype none
// ============================================================================
//  Module      : watchdog_reset_req
//  Description : Watchdog timer and reset-request source. A down-counter is
//                reloaded by kicks; if it expires the block raises a
//                fixed-length active-high reset request, sets a sticky
//                timeout flag, and before that gives an early warning for the
//                last WARN cycles. All outputs are driven directly by flops.
//  Revision    : 1.0  initial release
// ============================================================================
module watchdog_reset_req
    import watchdog_reset_req_pkg::*;
#(
    parameter int W       = 16,
    parameter int TIMEOUT = 50000,
    parameter int WARN    = 1000,
    parameter int PULSE   = 8
) (
    input  logic         clock,
    input  logic         reset_ni,
    input  logic         enable_i,
    input  logic         kick_i,
    input  logic         clear_i,
    output logic         warn_o,
    output logic         timeout_o,
    output logic         reset_req_o,
    output logic [W-1:0] count_o
);

    // Reload value gives exactly TIMEOUT edges from reload to FIRE entry,
    // because the edge that sees count==0 is the one that enters FIRE.
    localparam logic [W-1:0] c_RELOAD = W'(TIMEOUT - 1);
    localparam logic [W-1:0] c_WARN   = W'(WARN);
    localparam logic [W-1:0] c_ONE    = W'(1);

    wdt_state_t   r_state;
    logic [W-1:0] r_count;
    logic         r_warn;
    logic         r_timeout;

    logic         w_armed;
    logic         w_fire;
    logic         w_pulse;
    logic         w_pulse_last;
    logic [W-1:0] w_dec;

    assign w_armed = wdt_is_armed(r_state);

    // Expiry: armed, not disabled, not kicked this cycle, and already at 0.
    // A kick at count 0 therefore wins and no request is raised.
    assign w_fire  = w_armed && enable_i && !kick_i && (r_count == '0);

    // Only used when r_count is non-zero, so it never wraps.
    assign w_dec   = r_count - c_ONE;

    // The fixed-length reset request comes from a reusable stretcher; its
    // output flop drives reset_req_o directly.
    pulse_stretch #(
        .PULSE (PULSE)
    ) u_pulse (
        .clock    (clock),
        .reset_ni (reset_ni),
        .load_i   (w_fire),
        .pulse_o  (w_pulse),
        .last_o   (w_pulse_last)
    );

    // Watchdog state machine, timeout counter, warning and sticky flag.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_state   <= WDT_IDLE;
            r_count   <= '0;
            r_warn    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                WDT_IDLE: begin
                    r_warn <= 1'b0;
                    if (enable_i) begin
                        r_state <= WDT_RUN;
                        r_count <= c_RELOAD;
                    end
                end

                WDT_RUN, WDT_WARN: begin
                    if (!enable_i) begin
                        r_state <= WDT_IDLE;
                        r_count <= '0;
                        r_warn  <= 1'b0;
                    end else if (kick_i) begin
                        r_state <= WDT_RUN;
                        r_count <= c_RELOAD;
                        r_warn  <= 1'b0;
                    end else if (r_count == '0) begin
                        r_state <= WDT_FIRE;
                        r_warn  <= 1'b0;
                    end else begin
                        r_count <= w_dec;
                        if (w_dec < c_WARN) begin
                            r_state <= WDT_WARN;
                            r_warn  <= 1'b1;
                        end else begin
                            r_state <= WDT_RUN;
                            r_warn  <= 1'b0;
                        end
                    end
                end

                WDT_FIRE: begin
                    // Kicks and enable changes are ignored until the whole
                    // request pulse has been delivered.
                    r_warn  <= 1'b0;
                    r_count <= '0;
                    if (w_pulse_last) begin
                        if (enable_i) begin
                            r_state <= WDT_RUN;
                            r_count <= c_RELOAD;
                        end else begin
                            r_state <= WDT_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= WDT_IDLE;
                    r_count <= '0;
                    r_warn  <= 1'b0;
                end
            endcase

            // Setting on expiry takes precedence over a coincident clear.
            if (w_fire) begin
                r_timeout <= 1'b1;
            end else if (clear_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign warn_o      = r_warn;
    assign timeout_o   = r_timeout;
    assign reset_req_o = w_pulse;
    assign count_o     = r_count;

endmodule : watchdog_reset_req
`default_nettype wire
